// File: rtl/riscv_io_uart_pkg.sv
// Shared constants and types for the memory-mapped IO block.
// Covers the select bit, the register indices, the STATUS bit positions and the TX state encoding.
package riscv_io_pkg;

  localparam int IO_SEL_BIT = 22;

  localparam logic [2:0] REG_TXDATA = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_LEDS   = 3'd2;
  localparam logic [2:0] REG_CYCLE  = 3'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

endpackage

// File: rtl/riscv_io_uart_if.sv
// Core data-port bus as seen by the IO block.
// The core drives address, store data and strobe; the IO block returns combinational read data.
interface riscv_io_uart_if;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic [31:0] io_rdata;

  modport master (output io_addr, output io_wdata, output io_we, input io_rdata);
  modport slave  (input io_addr, input io_wdata, input io_we, output io_rdata);
endinterface

// File: rtl/riscv_io_uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// A push is accepted when full if a pop happens in the same cycle.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/riscv_io_uart.sv
// IO slave behind the M stage: buffered 8N1 UART transmitter, LED register, cycle counter.
// Selected by io_addr[22]; read data is combinational from the address.
module riscv_io_uart
  import riscv_io_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_io_uart_if.slave        bus,
  output logic                  uart_tx,
  output logic [7:0]            leds
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic        sel;
  logic        wr;
  logic [2:0]  idx;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [CW-1:0] fifo_count;
  logic        ovf;
  logic [31:0] cycle;
  logic [31:0] rdata;
  logic        busy;
  logic        unused_bits;

  tx_state_t   state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]  bit_cnt, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n;
  logic        bit_end;

  assign sel  = bus.io_addr[IO_SEL_BIT];
  assign wr   = bus.io_we && sel;
  assign idx  = bus.io_addr[4:2];
  assign push = wr && (idx == REG_TXDATA);
  assign busy = (state != TX_IDLE);
  assign unused_bits = ^{bus.io_addr[31:23], bus.io_addr[21:5], bus.io_addr[1:0], bus.io_wdata[31:8]};

  io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.io_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_end = (baud_cnt == BW'(CPB - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n = state;
    baud_n  = baud_cnt + BW'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    tx_n    = uart_tx;
    pop     = 1'b0;
    unique case (state)
      TX_IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_dout;
          tx_n    = 1'b0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          baud_n  = '0;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
          bit_n   = 3'd0;
          state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            tx_n    = 1'b1;
            state_n = TX_STOP;
          end else begin
            tx_n    = shreg[0];
            shreg_n = shreg >> 1;
            bit_n   = bit_cnt + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (!fifo_empty) begin
            // Next frame starts without an idle gap.
            pop     = 1'b1;
            shreg_n = fifo_dout;
            tx_n    = 1'b0;
            state_n = TX_START;
          end else begin
            tx_n    = 1'b1;
            state_n = TX_IDLE;
          end
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      uart_tx  <= tx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds  <= '0;
      ovf   <= 1'b0;
      cycle <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (wr && idx == REG_LEDS) leds <= bus.io_wdata[7:0];
      if (wr && idx == REG_STATUS)       ovf <= 1'b0;
      else if (push && fifo_full && !pop) ovf <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (idx)
        REG_STATUS: begin
          rdata[ST_COUNT_LSB +: 8] = 8'(fifo_count);
          rdata[ST_OVF]            = ovf;
          rdata[ST_BUSY]           = busy;
          rdata[ST_EMPTY]          = fifo_empty;
          rdata[ST_FULL]           = fifo_full;
        end
        REG_LEDS:  rdata[7:0] = leds;
        REG_CYCLE: rdata      = cycle;
        default:   rdata      = '0;
      endcase
    end
  end

  assign bus.io_rdata = rdata;

endmodule

// File: tb/tb_riscv_io_uart.sv
// Bench for riscv_io_uart: frame-position model of the UART, FIFO and registers, checked every cycle,
// plus directed scenarios with hand-computed expectations and a serial receiver.
module tb_riscv_io_uart;

  localparam int CPB   = 10;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  localparam logic [31:0] A_TX  = 32'h0040_0000;
  localparam logic [31:0] A_ST  = 32'h0040_0004;
  localparam logic [31:0] A_LED = 32'h0040_0008;
  localparam logic [31:0] A_CYC = 32'h0040_000C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_tx;
  logic [7:0] leds;

  riscv_io_uart_if bus();

  riscv_io_uart #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .uart_tx (uart_tx),
    .leds    (leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue and the position inside the frame being sent.
  logic [7:0]  m_q[$];
  bit          m_active;
  int          m_t;
  logic [7:0]  m_cur;
  bit          m_ovf;
  logic [7:0]  m_leds;
  logic [31:0] m_cycle;

  always @(posedge clk) begin
    int  pre;
    bit  popped;
    bit  wr;
    pre    = m_q.size();
    popped = 1'b0;
    wr     = bus.io_we && bus.io_addr[22];
    if (reset) begin
      m_q.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
      m_leds   = 8'h00;
      m_cycle  = 32'd0;
    end else begin
      m_cycle = m_cycle + 32'd1;
      if (m_active) begin
        if (m_t == FRAME - 1) begin
          if (pre > 0) begin
            m_cur = m_q.pop_front(); m_t = 0; popped = 1'b1;
          end else m_active = 1'b0;
        end else m_t++;
      end else if (pre > 0) begin
        m_cur = m_q.pop_front(); m_active = 1'b1; m_t = 0; popped = 1'b1;
      end
      if (wr) begin
        case (bus.io_addr[4:2])
          3'd0: if (pre < DEPTH || popped) m_q.push_back(bus.io_wdata[7:0]); else m_ovf = 1'b1;
          3'd1: m_ovf = 1'b0;
          3'd2: m_leds = bus.io_wdata[7:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic exp_line();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_cur[b-1];
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] r;
    int n;
    r = 32'd0;
    n = m_q.size();
    if (a[22]) begin
      case (a[4:2])
        3'd1: r = {16'd0, 8'(n), 4'd0, m_ovf, m_active, (n == 0), (n == DEPTH)};
        3'd2: r = {24'd0, m_leds};
        3'd3: r = m_cycle;
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("uart_tx", uart_tx, exp_line());
      check("leds", leds, m_leds);
      check("rdata", bus.io_rdata, exp_rdata(bus.io_addr));
    end
  end

  // Serial receiver sampling mid-bit.
  logic [7:0] rx_q[$];
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (chk_en && !reset && uart_tx === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  task automatic step(input logic [31:0] a, input logic [31:0] w, input logic we);
    bus.io_addr  = a;
    bus.io_wdata = w;
    bus.io_we    = we;
    @(posedge clk); #2;
    bus.io_we    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic read(input logic [31:0] a, output logic [31:0] d);
    bus.io_addr = a;
    #1 d = bus.io_rdata;
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic [31:0] s;
    int n;
    n = 0;
    read(A_ST, s);
    while ((s[2] || !s[1]) && n < budget) begin
      idle(1); n++;
      read(A_ST, s);
    end
    if (n >= budget) check({name, "_timeout"}, n, 32'(budget - 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d0;
    logic [9:0]  pat55;
    int n, lows;

    bus.io_addr = 32'd0; bus.io_wdata = 32'd0; bus.io_we = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk_en = 1'b1;

    // 1. Reset state and cycle counter.
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_leds", leds, 8'h00);
    read(A_ST, d);  check("reset_status", d, 32'h0000_0002);
    idle(50);
    check("idle_uart_tx", uart_tx, 1'b1);
    for (int i = 0; i < 4; i++) begin
      read(A_CYC, d0); idle(1); read(A_CYC, d);
      check("cycle_step", d - d0, 32'd1);
    end

    // 2. Single frame of 0x55: start, 1,0,1,0,1,0,1,0, stop.
    pat55 = 10'b1_0101_0101_0;
    step(A_TX, 32'h55, 1'b1);
    bus.io_addr = A_ST;
    idle(5);
    for (int b = 0; b < 10; b++) begin
      check("frame55_bit", uart_tx, pat55[b]);
      read(A_ST, d); check("frame55_busy", d[2], 1'b1);
      idle(CPB);
    end
    wait_idle(50, "frame55");
    read(A_ST, d); check("after55_status", d, 32'h0000_0002);

    // 3. Back-to-back frames without a gap.
    step(A_TX, 32'hA1, 1'b1);
    step(A_TX, 32'h3C, 1'b1);
    read(A_ST, d); check("b2b_count1", d, 32'h0000_0104);
    n = 0;
    while (d[2] && n < 400) begin
      idle(1); n++;
      read(A_ST, d);
      if (n == 50)  check("b2b_mid1", d, 32'h0000_0104);
      if (n == 150) check("b2b_mid2", d, 32'h0000_0006);
    end
    check("b2b_total_cycles", n, 32'd200);

    // 4. Overflow: 17 bytes accepted, 18th dropped.
    rx_q.delete();
    for (int i = 0; i < 17; i++) step(A_TX, 32'h30 + i, 1'b1);
    read(A_ST, d); check("ovf_after17", d[3], 1'b0);
    step(A_TX, 32'hEE, 1'b1);
    read(A_ST, d); check("ovf_after18", d, 32'h0000_100D);
    step(A_ST, 32'h0, 1'b1);
    read(A_ST, d); check("ovf_cleared", d, 32'h0000_1005);
    wait_idle(17 * FRAME + 100, "ovf_drain");
    idle(CPB);
    check("rx_count", rx_q.size(), 32'd17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) check("rx_byte", rx_q[i], 8'h30 + i);

    // 5. LED register and deselected access.
    step(A_LED, 32'hFFFF_FFA5, 1'b1);
    check("leds_write", leds, 8'hA5);
    read(A_LED, d); check("leds_read", d, 32'h0000_00A5);
    step(32'h0000_0008, 32'h0000_005A, 1'b1);
    check("leds_unsel", leds, 8'hA5);
    read(32'h0000_0008, d); check("rdata_unsel", d, 32'h0);

    // 6. Reset during data bit 3 of 0x0F aborts the frame.
    step(A_TX, 32'h0F, 1'b1);
    idle(44);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("abort_uart_tx", uart_tx, 1'b1);
    read(A_ST, d); check("abort_status", d, 32'h0000_0002);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      idle(1);
      if (uart_tx !== 1'b1) lows++;
    end
    check("abort_no_frame", lows, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
